// File: rtl/model_vector_integer_streamer.sv
// Element transmitter: holds a host-loaded vector and, on START, sends it out
// one element per DATA_OUT_ENABLE strobe, waiting for ACK between elements.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | buffer writable; waits for START; pulses READY on empty/error
// EMIT     | loads buffer[index] onto DATA_OUT and raises the strobe
// WAIT_ACK | strobe low again; waits for ACK, then next element or done
module model_vector_integer_streamer #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int ADDRESS_SIZE = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START_i,
    output logic                    READY_o,
    input  logic                    WRITE_ENABLE_i,
    input  logic [ADDRESS_SIZE-1:0] WRITE_ADDRESS_i,
    input  logic [DATA_SIZE-1:0]    WRITE_DATA_i,
    input  logic [DATA_SIZE-1:0]    SIZE_IN_i,
    output logic                    DATA_OUT_ENABLE_o,
    output logic [DATA_SIZE-1:0]    DATA_OUT_o,
    input  logic                    ACK_IN_i,
    output logic                    ERROR_OUT_o
);

    localparam int DEPTH = 2 ** ADDRESS_SIZE;
    localparam logic [DATA_SIZE-1:0] DEPTH_W = DATA_SIZE'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EMIT     = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CONTROL_SIZE-1:0] index_q, index_d;
    logic [DATA_SIZE-1:0]    size_q, size_d;
    logic [DATA_SIZE-1:0]    data_q, data_d;
    logic                    en_q, en_d;
    logic                    ready_q, ready_d;
    logic                    error_q, error_d;

    logic [DATA_SIZE-1:0]    buf_q [DEPTH];
    logic [CONTROL_SIZE-1:0] size_ctl;
    logic                    wr_en;

    // The index is compared against the latched size cut to the counter width.
    assign size_ctl = CONTROL_SIZE'(size_q);
    // The buffer is frozen outside IDLE so a transfer always sees a stable vector.
    assign wr_en    = (state_q == IDLE) && WRITE_ENABLE_i;

    assign READY_o           = ready_q;
    assign DATA_OUT_ENABLE_o = en_q;
    assign DATA_OUT_o        = data_q;
    assign ERROR_OUT_o       = error_q;

    // Vector buffer; contents deliberately survive reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            buf_q[WRITE_ADDRESS_i] <= WRITE_DATA_i;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            index_q <= '0;
            size_q  <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            size_q  <= size_d;
            data_q  <= data_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    // Next-state and registered-output logic; READY and the strobe default low
    // so each is a single-cycle pulse.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        size_d  = size_q;
        data_d  = data_q;
        en_d    = 1'b0;
        ready_d = 1'b0;
        error_d = error_q;
        case (state_q)
            IDLE: begin
                if (START_i) begin
                    error_d = 1'b0;
                    size_d  = SIZE_IN_i;
                    if (SIZE_IN_i == '0) begin
                        ready_d = 1'b1;
                    end else if (SIZE_IN_i > DEPTH_W) begin
                        error_d = 1'b1;
                        ready_d = 1'b1;
                    end else begin
                        index_d = '0;
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                data_d  = buf_q[index_q[ADDRESS_SIZE-1:0]];
                en_d    = 1'b1;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ACK_IN_i) begin
                    if (index_q == size_ctl - CONTROL_SIZE'(1)) begin
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        index_d = index_q + CONTROL_SIZE'(1);
                        state_d = EMIT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_model_vector_integer_streamer.sv
// Directed bench for the vector element streamer: a per-cycle vector table for
// the straight-line cases, hand-written sequences for the multi-cycle corners.
module tb_model_vector_integer_streamer;

    logic        CLK;
    logic        RST;
    logic        START_i;
    logic        READY_o;
    logic        WRITE_ENABLE_i;
    logic [3:0]  WRITE_ADDRESS_i;
    logic [63:0] WRITE_DATA_i;
    logic [63:0] SIZE_IN_i;
    logic        DATA_OUT_ENABLE_o;
    logic [63:0] DATA_OUT_o;
    logic        ACK_IN_i;
    logic        ERROR_OUT_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        start;
        logic        we;
        logic [3:0]  waddr;
        logic [63:0] wdata;
        logic [63:0] size;
        logic        ack;
        logic        en;
        logic        rdy;
        logic        err;
        logic [63:0] dout;
    } vec_t;

    vec_t vecs[$];

    model_vector_integer_streamer #(
        .DATA_SIZE   (64),
        .CONTROL_SIZE(64),
        .ADDRESS_SIZE(4)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .START_i          (START_i),
        .READY_o          (READY_o),
        .WRITE_ENABLE_i   (WRITE_ENABLE_i),
        .WRITE_ADDRESS_i  (WRITE_ADDRESS_i),
        .WRITE_DATA_i     (WRITE_DATA_i),
        .SIZE_IN_i        (SIZE_IN_i),
        .DATA_OUT_ENABLE_o(DATA_OUT_ENABLE_o),
        .DATA_OUT_o       (DATA_OUT_o),
        .ACK_IN_i         (ACK_IN_i),
        .ERROR_OUT_o      (ERROR_OUT_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic en, input logic [63:0] dout,
                           input logic rdy, input logic err);
        chk({tag, "_en"},  {63'd0, DATA_OUT_ENABLE_o}, {63'd0, en});
        chk({tag, "_dout"}, DATA_OUT_o, dout);
        chk({tag, "_rdy"}, {63'd0, READY_o}, {63'd0, rdy});
        chk({tag, "_err"}, {63'd0, ERROR_OUT_o}, {63'd0, err});
    endtask

    task automatic add_vec(input logic start, input logic we, input logic [3:0] waddr,
                           input logic [63:0] wdata, input logic [63:0] size, input logic ack,
                           input logic en, input logic rdy, input logic err,
                           input logic [63:0] dout);
        vec_t v;
        v.start = start; v.we = we; v.waddr = waddr; v.wdata = wdata; v.size = size;
        v.ack = ack; v.en = en; v.rdy = rdy; v.err = err; v.dout = dout;
        vecs.push_back(v);
    endtask

    initial begin
        logic [63:0] exp_el [4];
        exp_el[0] = 64'd5; exp_el[1] = 64'd7; exp_el[2] = 64'd9; exp_el[3] = 64'd11;

        RST = 1'b1; START_i = 1'b0; WRITE_ENABLE_i = 1'b0; WRITE_ADDRESS_i = '0;
        WRITE_DATA_i = '0; SIZE_IN_i = '0; ACK_IN_i = 1'b0;
        #2;
        chk_out("reset", 1'b0, 64'd0, 1'b0, 1'b0);
        #5;
        RST = 1'b0;
        tick();

        // start we  wa  wdata  size ack | en rdy err dout
        add_vec(0, 1, 0, 5,  0, 0, 0, 0, 0, 0);
        add_vec(0, 1, 1, 7,  0, 0, 0, 0, 0, 0);
        add_vec(0, 1, 2, 9,  0, 0, 0, 0, 0, 0);
        add_vec(0, 1, 3, 11, 0, 0, 0, 0, 0, 0);
        // four elements, ACK tied high
        add_vec(1, 0, 0, 0, 4, 1, 0, 0, 0, 0);
        add_vec(0, 0, 0, 0, 4, 1, 1, 0, 0, 5);
        add_vec(0, 0, 0, 0, 4, 1, 0, 0, 0, 5);
        add_vec(0, 0, 0, 0, 4, 1, 1, 0, 0, 7);
        add_vec(0, 0, 0, 0, 4, 1, 0, 0, 0, 7);
        add_vec(0, 0, 0, 0, 4, 1, 1, 0, 0, 9);
        add_vec(0, 0, 0, 0, 4, 1, 0, 0, 0, 9);
        add_vec(0, 0, 0, 0, 4, 1, 1, 0, 0, 11);
        add_vec(0, 0, 0, 0, 4, 1, 0, 1, 0, 11);
        add_vec(0, 0, 0, 0, 4, 0, 0, 0, 0, 11);
        // empty transfer
        add_vec(1, 0, 0, 0, 0, 0, 0, 1, 0, 11);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 11);
        // oversize transfer, then a valid one clears the error
        add_vec(1, 0, 0, 0, 17, 0, 0, 1, 1, 11);
        add_vec(0, 0, 0, 0, 17, 0, 0, 0, 1, 11);
        add_vec(1, 0, 0, 0, 1, 1, 0, 0, 0, 11);
        add_vec(0, 0, 0, 0, 1, 1, 1, 0, 0, 5);
        add_vec(0, 0, 0, 0, 1, 1, 0, 1, 0, 5);
        add_vec(0, 0, 0, 0, 1, 0, 0, 0, 0, 5);
        // exact-depth transfer is legal (16 elements, no error, starts)
        add_vec(1, 0, 0, 0, 16, 0, 0, 0, 0, 5);

        for (int i = 0; i < vecs.size(); i++) begin
            START_i         = vecs[i].start;
            WRITE_ENABLE_i  = vecs[i].we;
            WRITE_ADDRESS_i = vecs[i].waddr;
            WRITE_DATA_i    = vecs[i].wdata;
            SIZE_IN_i       = vecs[i].size;
            ACK_IN_i        = vecs[i].ack;
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].en, vecs[i].dout, vecs[i].rdy, vecs[i].err);
        end
        START_i = 1'b0; WRITE_ENABLE_i = 1'b0; ACK_IN_i = 1'b0;

        // abandon the 16-element run through reset; buffer must survive
        RST = 1'b1;
        #1;
        RST = 1'b0;
        tick();

        // ACK delayed three cycles after every strobe
        SIZE_IN_i = 64'd4; START_i = 1'b1;
        tick();
        START_i = 1'b0;
        for (int e = 0; e < 4; e++) begin
            tick();
            chk_out($sformatf("dly_strobe%0d", e), 1'b1, exp_el[e], 1'b0, 1'b0);
            for (int w = 0; w < 3; w++) begin
                tick();
                chk_out($sformatf("dly_hold%0d_%0d", e, w), 1'b0, exp_el[e], 1'b0, 1'b0);
            end
            ACK_IN_i = 1'b1;
            tick();
            ACK_IN_i = 1'b0;
            chk($sformatf("dly_rdy%0d", e), {63'd0, READY_o}, (e == 3) ? 64'd1 : 64'd0);
        end
        ACK_IN_i = 1'b1;
        for (int w = 0; w < 3; w++) begin
            tick();
            chk_out($sformatf("idle_ack%0d", w), 1'b0, 64'd11, 1'b0, 1'b0);
        end
        ACK_IN_i = 1'b0;

        // write attempt during WAIT_ACK must not reach the buffer
        SIZE_IN_i = 64'd2; START_i = 1'b1;
        tick();
        START_i = 1'b0;
        tick();
        chk_out("frz_e0", 1'b1, 64'd5, 1'b0, 1'b0);
        WRITE_ENABLE_i = 1'b1; WRITE_ADDRESS_i = 4'd1; WRITE_DATA_i = 64'd99;
        tick();
        WRITE_ENABLE_i = 1'b0;
        ACK_IN_i = 1'b1;
        tick();
        ACK_IN_i = 1'b0;
        tick();
        chk_out("frz_e1", 1'b1, 64'd7, 1'b0, 1'b0);
        ACK_IN_i = 1'b1;
        tick();
        chk_out("frz_done", 1'b0, 64'd7, 1'b1, 1'b0);
        START_i = 1'b1;
        tick();
        START_i = 1'b0;
        tick();
        chk_out("rerun_e0", 1'b1, 64'd5, 1'b0, 1'b0);
        tick();
        tick();
        chk_out("rerun_e1", 1'b1, 64'd7, 1'b0, 1'b0);
        tick();
        chk_out("rerun_done", 1'b0, 64'd7, 1'b1, 1'b0);
        ACK_IN_i = 1'b0;

        // reset in WAIT_ACK of the second element
        SIZE_IN_i = 64'd4; START_i = 1'b1;
        tick();
        START_i = 1'b0;
        tick();
        ACK_IN_i = 1'b1;
        tick();
        ACK_IN_i = 1'b0;
        tick();
        chk_out("pre_rst", 1'b1, 64'd7, 1'b0, 1'b0);
        RST = 1'b1;
        #1;
        chk_out("mid_rst", 1'b0, 64'd0, 1'b0, 1'b0);
        #1;
        RST = 1'b0;
        for (int w = 0; w < 2; w++) begin
            tick();
            chk_out($sformatf("post_rst%0d", w), 1'b0, 64'd0, 1'b0, 1'b0);
        end
        START_i = 1'b1; ACK_IN_i = 1'b1;
        tick();
        START_i = 1'b0;
        for (int e = 0; e < 4; e++) begin
            tick();
            chk_out($sformatf("rst_rerun_e%0d", e), 1'b1, exp_el[e], 1'b0, 1'b0);
            tick();
            chk($sformatf("rst_rerun_rdy%0d", e), {63'd0, READY_o}, (e == 3) ? 64'd1 : 64'd0);
        end
        ACK_IN_i = 1'b0;
        tick();

        // START held high: retrigger only from IDLE after READY
        SIZE_IN_i = 64'd2; START_i = 1'b1; ACK_IN_i = 1'b1;
        tick();
        chk_out("hold_start", 1'b0, 64'd11, 1'b0, 1'b0);
        tick();
        chk_out("hold_e0", 1'b1, 64'd5, 1'b0, 1'b0);
        tick();
        chk_out("hold_w0", 1'b0, 64'd5, 1'b0, 1'b0);
        tick();
        chk_out("hold_e1", 1'b1, 64'd7, 1'b0, 1'b0);
        tick();
        chk_out("hold_done", 1'b0, 64'd7, 1'b1, 1'b0);
        tick();
        chk_out("hold_restart", 1'b0, 64'd7, 1'b0, 1'b0);
        START_i = 1'b0;
        tick();
        chk_out("hold_r_e0", 1'b1, 64'd5, 1'b0, 1'b0);
        tick();
        tick();
        chk_out("hold_r_e1", 1'b1, 64'd7, 1'b0, 1'b0);
        tick();
        chk_out("hold_r_done", 1'b0, 64'd7, 1'b1, 1'b0);
        ACK_IN_i = 1'b0;
        tick();
        chk_out("final_idle", 1'b0, 64'd7, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
